// File: rtl/two_phase_sequencer.sv
// Two-phase resource sequencer: alternately grants a shared resource to a phase-1
// and a phase-2 requester with mutual exclusion, an idle gap and a hold-time limit.
module two_phase_sequencer #(
    parameter int HOLD_MAX = 8,
    parameter int STRICT   = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic             done1,
    input  logic             req2,
    input  logic             done2,
    output logic             gnt1,
    output logic             gnt2,
    output logic             busy,
    output logic             last_phase,
    output logic             err_timeout,
    output logic [CNT_W-1:0] rounds
);
    localparam int HW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {IDLE, PH1, PH2} state_t;

    state_t          state, state_n;
    logic [HW-1:0]   hold_cnt;
    logic            leave, tout;

    always_comb begin
        state_n = state;
        leave   = 1'b0;
        tout    = 1'b0;
        case (state)
            IDLE: begin
                if (STRICT != 0) begin
                    // Only the phase opposite the last served one may be granted.
                    if (last_phase && req1)
                        state_n = PH1;
                    else if (!last_phase && req2)
                        state_n = PH2;
                end else begin
                    if (req1 && req2)
                        state_n = last_phase ? PH1 : PH2;
                    else if (req1)
                        state_n = PH1;
                    else if (req2)
                        state_n = PH2;
                end
            end
            PH1, PH2: begin
                if ((state == PH1) ? done1 : done2)
                    leave = 1'b1;
                else if (hold_cnt == HW'(HOLD_MAX)) begin
                    leave = 1'b1;
                    tout  = 1'b1;
                end
                if (leave)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            last_phase  <= 1'b1;
            err_timeout <= 1'b0;
            rounds      <= '0;
        end else begin
            state <= state_n;
            // Counter holds the index of the current grant-high cycle.
            if (state == IDLE && state_n != IDLE)
                hold_cnt <= HW'(1);
            else if (state != IDLE && !leave)
                hold_cnt <= hold_cnt + HW'(1);
            else
                hold_cnt <= '0;
            if (leave) begin
                last_phase <= (state == PH2);
                if (state == PH2)
                    rounds <= rounds + CNT_W'(1);
                if (tout)
                    err_timeout <= 1'b1;
            end
        end
    end

    assign gnt1 = (state == PH1);
    assign gnt2 = (state == PH2);
    assign busy = gnt1 | gnt2;

endmodule

// File: tb/tb_two_phase_sequencer.sv
// Directed bench for two_phase_sequencer: a strict instance (CNT_W=2) and a
// non-strict instance share clock and reset.
module tb_two_phase_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic a_req1, a_done1, a_req2, a_done2;
    logic a_gnt1, a_gnt2, a_busy, a_last, a_err;
    logic [1:0] a_rounds;
    logic b_req1, b_done1, b_req2, b_done2;
    logic b_gnt1, b_gnt2, b_busy, b_last, b_err;
    logic [7:0] b_rounds;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    two_phase_sequencer #(.HOLD_MAX(8), .STRICT(1), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .req1(a_req1), .done1(a_done1), .req2(a_req2),
        .done2(a_done2), .gnt1(a_gnt1), .gnt2(a_gnt2), .busy(a_busy),
        .last_phase(a_last), .err_timeout(a_err), .rounds(a_rounds));

    two_phase_sequencer #(.HOLD_MAX(8), .STRICT(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .req1(b_req1), .done1(b_done1), .req2(b_req2),
        .done2(b_done2), .gnt1(b_gnt1), .gnt2(b_gnt2), .busy(b_busy),
        .last_phase(b_last), .err_timeout(b_err), .rounds(b_rounds));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {a_req1, a_done1, a_req2, a_done2} = '0;
        {b_req1, b_done1, b_req2, b_done2} = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_gnt1, a_gnt2, a_busy, a_last, a_err, a_rounds} !== 7'b0001000) begin
            failures++;
            $display("FAIL reset_state got=%b want=0001000",
                     {a_gnt1, a_gnt2, a_busy, a_last, a_err, a_rounds});
        end
        a_req2 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (a_gnt1 !== 1'b0 || a_gnt2 !== 1'b0) begin
                failures++;
                $display("FAIL strict_holdoff cyc=%0d gnt1=%b gnt2=%b want=0,0", c, a_gnt1, a_gnt2);
            end
        end
        a_req1 = 1'b1;
        tick();
        checks++;
        if (a_gnt1 !== 1'b1 || a_gnt2 !== 1'b0 || a_busy !== 1'b1 || a_last !== 1'b1) begin
            failures++;
            $display("FAIL first_grant gnt1=%b gnt2=%b busy=%b last=%b want=1,0,1,1",
                     a_gnt1, a_gnt2, a_busy, a_last);
        end
        tick();
        checks++;
        if (a_last !== 1'b1) begin
            failures++;
            $display("FAIL last_before_done got=%b want=1", a_last);
        end
        a_done1 = 1'b1;
        a_req1  = 1'b0;
        a_req2  = 1'b0;
        tick();
        a_done1 = 1'b0;
        checks++;
        if (a_gnt1 !== 1'b0 || a_last !== 1'b0 || a_rounds !== 2'd0) begin
            failures++;
            $display("FAIL release gnt1=%b last=%b rounds=%0d want=0,0,0", a_gnt1, a_last, a_rounds);
        end
    endtask

    task automatic test_alternation();
        logic exp2;
        int r;
        do_reset();
        a_req1 = 1'b1;
        a_req2 = 1'b1;
        r = 0;
        tick();
        for (int g = 0; g < 6; g++) begin
            exp2 = (g % 2 == 1);
            for (int c = 1; c <= 2; c++) begin
                checks++;
                if (a_gnt1 !== !exp2 || a_gnt2 !== exp2 || (a_gnt1 & a_gnt2)) begin
                    failures++;
                    $display("FAIL alt_grant g=%0d c=%0d gnt1=%b gnt2=%b want=%b,%b",
                             g, c, a_gnt1, a_gnt2, !exp2, exp2);
                end
                if (c == 2) begin
                    if (exp2) a_done2 = 1'b1;
                    else      a_done1 = 1'b1;
                end
                tick();
            end
            a_done1 = 1'b0;
            a_done2 = 1'b0;
            if (exp2) r++;
            checks++;
            if (a_busy !== 1'b0 || a_rounds !== 2'(r) || a_last !== exp2) begin
                failures++;
                $display("FAIL alt_gap g=%0d busy=%b rounds=%0d last=%b want=0,%0d,%b",
                         g, a_busy, a_rounds, a_last, r, exp2);
            end
            tick();
        end
        checks++;
        if (a_rounds !== 2'd3) begin
            failures++;
            $display("FAIL alt_rounds got=%0d want=3", a_rounds);
        end
        a_req1 = 1'b0;
        a_req2 = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        a_req1 = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (a_gnt1 !== 1'b1 || a_err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_hold c=%0d gnt1=%b err=%b want=1,0", c, a_gnt1, a_err);
            end
            tick();
        end
        checks++;
        if (a_gnt1 !== 1'b0 || a_err !== 1'b1 || a_last !== 1'b0) begin
            failures++;
            $display("FAIL timeout_release gnt1=%b err=%b last=%b want=0,1,0", a_gnt1, a_err, a_last);
        end
        a_req2 = 1'b1;
        tick();
        checks++;
        if (a_gnt2 !== 1'b1 || a_gnt1 !== 1'b0 || a_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_next gnt1=%b gnt2=%b err=%b want=0,1,1", a_gnt1, a_gnt2, a_err);
        end
        a_done2 = 1'b1;
        a_req1  = 1'b0;
        a_req2  = 1'b0;
        tick();
        a_done2 = 1'b0;
        checks++;
        if (a_err !== 1'b1 || a_rounds !== 2'd1 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky err=%b rounds=%0d busy=%b want=1,1,0", a_err, a_rounds, a_busy);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        a_req1 = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (a_gnt1 !== 1'b1) begin
                failures++;
                $display("FAIL boundary_hold c=%0d gnt1=%b want=1", c, a_gnt1);
            end
            a_done2 = (c == 3);
            a_done1 = (c == 8);
            tick();
        end
        a_done1 = 1'b0;
        a_done2 = 1'b0;
        a_req1  = 1'b0;
        checks++;
        if (a_gnt1 !== 1'b0 || a_err !== 1'b0 || a_last !== 1'b0 || a_rounds !== 2'd0) begin
            failures++;
            $display("FAIL boundary_done gnt1=%b err=%b last=%b rounds=%0d want=0,0,0,0",
                     a_gnt1, a_err, a_last, a_rounds);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_r [5];
        int k;
        exp_r = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        a_req1 = 1'b1;
        a_req2 = 1'b1;
        k = 0;
        tick();
        for (int g = 0; g < 10; g++) begin
            if (g % 2 == 1) a_done2 = 1'b1;
            else            a_done1 = 1'b1;
            tick();
            a_done1 = 1'b0;
            a_done2 = 1'b0;
            if (g % 2 == 1) begin
                checks++;
                if (a_rounds !== exp_r[k]) begin
                    failures++;
                    $display("FAIL wrap_rounds k=%0d got=%0d want=%0d", k, a_rounds, exp_r[k]);
                end
                k++;
            end
            tick();
        end
        a_req1 = 1'b0;
        a_req2 = 1'b0;
    endtask

    task automatic test_nonstrict_reset();
        do_reset();
        b_req1 = 1'b1;
        for (int g = 0; g < 2; g++) begin
            tick();
            checks++;
            if (b_gnt1 !== 1'b1 || b_gnt2 !== 1'b0) begin
                failures++;
                $display("FAIL nonstrict_regrant g=%0d gnt1=%b gnt2=%b want=1,0", g, b_gnt1, b_gnt2);
            end
            b_done1 = 1'b1;
            tick();
            b_done1 = 1'b0;
        end
        b_req1 = 1'b0;
        b_req2 = 1'b1;
        tick();
        checks++;
        if (b_gnt2 !== 1'b1 || b_gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL nonstrict_gnt2 gnt1=%b gnt2=%b want=0,1", b_gnt1, b_gnt2);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({b_gnt1, b_gnt2, b_busy, b_last, b_err, b_rounds} !== 13'b0001000000000) begin
            failures++;
            $display("FAIL midgrant_reset got=%b want=0001000000000",
                     {b_gnt1, b_gnt2, b_busy, b_last, b_err, b_rounds});
        end
        rst_n  = 1'b1;
        b_req2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_timeout();
        test_boundary();
        test_wrap();
        test_nonstrict_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
